id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- Pipeline register between the decode stage (control decoder, register file, condition check) and the execute stage.
- Latches decoded control bits, operands and instruction fields each cycle.
- Squashes control bits into a bubble on a data hazard, a failed condition or a branch flush.
- Counts inserted bubbles for performance debug.

Parameters:
- DATA_W, 32, width of PC and operand values
- CNT_W, 16, width of the saturating bubble counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- freeze  in  1  hold all registered state (execute/memory stall)
- flush  in  1  branch taken in execute; squash the instruction being loaded
- hazard  in  1  decode-stage data hazard; insert a bubble
- cond_pass  in  1  instruction condition satisfied by current status flags
- exe_cmd_in  in  4  ALU command from the decoder
- s_update_in, branch_in, mem_w_en_in, mem_r_en_in, wb_en_in  in  1 each  decoder control bits
- pc_in  in  DATA_W  PC+4 of the decode instruction
- val_rn_in, val_rm_in  in  DATA_W  register operands
- imm_in  in  1  immediate-operand flag
- shift_operand_in  in  12  shifter operand field
- simm24_in  in  24  branch offset field
- dest_in  in  4  destination register
- sr_in  in  4  status flags {N,Z,C,V}
- src1_in, src2_in  in  4 each  source register numbers (used only with the optional feature)
- Matching registered outputs, all suffixed _out, same widths as the inputs above
- valid_out  out  1  registered slot holds a real instruction
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Single clock, synchronous active-high reset on clk: rst=1 at a rising edge clears every output, including valid_out and bubble_cnt, to 0 by the next edge.
- Per-edge priority: rst > flush > freeze > hazard > normal load.
- Flush:
  - Loads a bubble: all control bits 0, exe_cmd_out=0, valid_out=0.
  - Data fields (pc, val_*, fields, dest, sr) are still loaded from the inputs.
  - Overrides freeze.
- Freeze (flush=0): every output holds its value; bubble_cnt holds.
- Hazard (freeze=0, flush=0): loads a bubble as for flush.
- Normal load:
  - Data fields load from the inputs.
  - valid_out=1.
  - If cond_pass=0, all control bits and exe_cmd_out load 0 and valid_out=0; this counts as a bubble.
  - Otherwise controls load straight through.
- Bubble definition: any loaded cycle (not rst, not freeze) with valid_out next = 0.
  - bubble_cnt increments by 1 per bubble.
  - Saturates at 2^CNT_W-1 and never wraps.
- Latency: exactly 1 cycle from input to output when not frozen.
- Controls are never X after reset; an undefined decoder output is forwarded as-is only when cond_pass=1 and the slot is valid.
- Reset mid-freeze: reset wins and clears everything.
- Simultaneous flush+hazard: one bubble, counted once.

Optional Feature:
- Macro: ID_EX_FWD_SRC_EN.
- Defined: src1_out/src2_out are registered with the same freeze/reset rules as dest_out. On a bubble they load 4'hF so the forwarding unit never matches a squashed slot.
- Undefined: src1_out/src2_out are constant 0, src1_in/src2_in are unused, and no flops are instantiated for them.

Test Plan:
- Reset: rst=1 with all inputs at 1s → next edge all outputs 0, bubble_cnt=0, valid_out=0; rst released → first load passes exe_cmd_in=4'b0010, wb_en_in=1 to outputs one cycle later with valid_out=1.
- Freeze: load pc_in=32'h10, then freeze=1 for 3 cycles while pc_in changes to 32'h14/18/1C → pc_out stays 32'h10, bubble_cnt unchanged; freeze=0 → pc_out=32'h1C next edge.
- Hazard: hazard=1 with mem_r_en_in=1, wb_en_in=1 → next edge mem_r_en_out=0, wb_en_out=0, valid_out=0, bubble_cnt=1.
- Condition fail: cond_pass=0 with mem_w_en_in=1, exe_cmd_in=4'b0100 → mem_w_en_out=0, exe_cmd_out=0, bubble_cnt increments; cond_pass=1 → values pass through.
- Flush vs freeze: flush=1, freeze=1, branch_in=1 → branch_out=0, valid_out=0, bubble counted once; flush+hazard together → bubble_cnt +1, not +2.
- Saturation, with CNT_W=4: hazard=1 for 20 cycles → bubble_cnt stops at 15; with ID_EX_FWD_SRC_EN defined, bubble cycles show src1_out=src2_out=4'hF.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: latches decoded controls, operands and fields, squashes
// controls into bubbles on flush/hazard/failed condition, counts bubbles (saturating).
// Optional macro ID_EX_FWD_SRC_EN registers src1/src2 for the forwarding unit.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              hazard,
    input  logic              cond_pass,
    input  logic [3:0]        exe_cmd_in,
    input  logic              s_update_in,
    input  logic              branch_in,
    input  logic              mem_w_en_in,
    input  logic              mem_r_en_in,
    input  logic              wb_en_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       simm24_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        sr_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    output logic [3:0]        exe_cmd_out,
    output logic              s_update_out,
    output logic              branch_out,
    output logic              mem_w_en_out,
    output logic              mem_r_en_out,
    output logic              wb_en_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       simm24_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        sr_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       s_update;
        logic       branch;
        logic       mem_w_en;
        logic       mem_r_en;
        logic       wb_en;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic              imm;
        logic [11:0]       shift_operand;
        logic [23:0]       simm24;
        logic [3:0]        dest;
        logic [3:0]        sr;
    } data_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t            ctrl_d, ctrl_q;
    data_t            data_d, data_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             load_c;
    logic             squash_c;

    // Flush overrides freeze; a squashed load is any load whose slot ends up invalid.
    assign load_c   = flush | ~freeze;
    assign squash_c = flush | hazard | ~cond_pass;

    always_comb begin
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (load_c) begin
            data_d  = '{pc: pc_in, val_rn: val_rn_in, val_rm: val_rm_in, imm: imm_in,
                        shift_operand: shift_operand_in, simm24: simm24_in,
                        dest: dest_in, sr: sr_in};
            ctrl_d  = '{exe_cmd: exe_cmd_in, s_update: s_update_in, branch: branch_in,
                        mem_w_en: mem_w_en_in, mem_r_en: mem_r_en_in, wb_en: wb_en_in};
            valid_d = 1'b1;
            if (squash_c) begin
                ctrl_d  = '0;
                valid_d = 1'b0;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ID_EX_FWD_SRC_EN
    logic [3:0] src1_d, src1_q;
    logic [3:0] src2_d, src2_q;

    // Squashed slots carry 4'hF so the forwarding unit never matches them.
    always_comb begin
        src1_d = src1_q;
        src2_d = src2_q;
        if (load_c) begin
            src1_d = squash_c ? 4'hF : src1_in;
            src2_d = squash_c ? 4'hF : src2_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src1_q <= '0;
            src2_q <= '0;
        end else begin
            src1_q <= src1_d;
            src2_q <= src2_d;
        end
    end

    assign src1_out = src1_q;
    assign src2_out = src2_q;
`else
    logic unused_src;
    assign unused_src = ^{src1_in, src2_in};
    assign src1_out   = 4'h0;
    assign src2_out   = 4'h0;
`endif

    assign exe_cmd_out       = ctrl_q.exe_cmd;
    assign s_update_out      = ctrl_q.s_update;
    assign branch_out        = ctrl_q.branch;
    assign mem_w_en_out      = ctrl_q.mem_w_en;
    assign mem_r_en_out      = ctrl_q.mem_r_en;
    assign wb_en_out         = ctrl_q.wb_en;
    assign pc_out            = data_q.pc;
    assign val_rn_out        = data_q.val_rn;
    assign val_rm_out        = data_q.val_rm;
    assign imm_out           = data_q.imm;
    assign shift_operand_out = data_q.shift_operand;
    assign simm24_out        = data_q.simm24;
    assign dest_out          = data_q.dest;
    assign sr_out            = data_q.sr;
    assign valid_out         = valid_q;
    assign bubble_cnt        = cnt_q;

endmodule
